// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter: shares one req/ack memory bus between fetch and MEM     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        stallreq_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_IF_BUSY  = 2'd1;
  localparam logic [1:0] c_MEM_BUSY = 2'd2;
  localparam logic [1:0] c_ABORT    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic [31:0] mem_hold_q, mem_hold_d;

  logic if_pend, mem_pend, if_ack, mem_ack;
  logic unused_stall;

  assign if_pend  = if_ce & ~if_done_q;
  assign mem_pend = mem_ce & ~mem_done_q;
  assign if_ack   = (state_q == c_IF_BUSY) & bus_ack & ~flush;
  assign mem_ack  = (state_q == c_MEM_BUSY) & bus_ack & ~flush;
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      sel_q      <= 4'h0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_hold_q  <= 32'h0;
      mem_hold_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_hold_q  <= if_hold_d;
      mem_hold_q <= mem_hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    if_hold_d  = if_hold_q;
    mem_hold_d = mem_hold_q;

    case (state_q)
      c_IDLE: begin
        if (!flush) begin
          if (mem_pend) begin
            state_d = c_MEM_BUSY;
            req_d   = 1'b1;
            we_d    = mem_we;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            sel_d   = mem_sel;
          end else if (if_pend) begin
            state_d = c_IF_BUSY;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = 32'h0;
            sel_d   = 4'hF;
          end
        end
      end
      c_IF_BUSY, c_MEM_BUSY: begin
        if (bus_ack) begin
          state_d = c_IDLE;
          req_d   = 1'b0;
        end else if (flush) begin
          state_d = c_ABORT;
        end
      end
      c_ABORT: begin
        // The abandoned transaction must still be closed by its one ack.
        if (bus_ack) begin
          state_d = c_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = c_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (if_ack && stall[1]) begin
      if_done_d = 1'b1;
      if_hold_d = bus_rdata;
    end else if (!stall[1] || flush) begin
      if_done_d = 1'b0;
    end

    if (mem_ack && stall[4]) begin
      mem_done_d = 1'b1;
      mem_hold_d = bus_rdata;
    end else if (!stall[4] || flush) begin
      mem_done_d = 1'b0;
    end
  end

  always_comb begin
    if_inst = 32'h0;
    if (if_ack) begin
      if_inst = bus_rdata;
    end else if (if_done_q) begin
      if_inst = if_hold_q;
    end

    mem_rdata = 32'h0;
    if (mem_ack) begin
      mem_rdata = bus_rdata;
    end else if (mem_done_q) begin
      mem_rdata = mem_hold_q;
    end

    stallreq_if  = if_pend & ~if_ack;
    stallreq_mem = mem_pend & ~mem_ack;
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory bus arbiter for the five-stage pipeline. It shares one request/acknowledge memory bus between the instruction-fetch side (pc/ce from the PC register) and the data-memory side (MEM stage). It tolerates variable slave wait states and raises per-side stall requests to the pipeline controller. It holds returned data across pipeline stalls, and on a flush it abandons in-flight transactions safely.

## Interface
- No parameters; bus is 32-bit address, 32-bit data, 4-bit byte select.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit1 = IF/ID hold, bit4 = MEM/WB hold
- flush  in  1  exception flush pulse
- if_ce  in  1  fetch enable
- if_addr  in  32  fetch address (pc)
- if_inst  out  32  fetched instruction
- stallreq_if  out  1  fetch side not ready
- mem_ce, mem_we  in  1 each  data access enable / write
- mem_addr, mem_wdata  in  32 each  data address / write data
- mem_sel  in  4  byte enables
- mem_rdata  out  32  load data
- stallreq_mem  out  1  data side not ready
- bus_req, bus_we  out  1 each  bus request / write
- bus_addr, bus_wdata  out  32 each  bus address / write data
- bus_sel  out  4  bus byte enables
- bus_rdata  in  32  bus read data
- bus_ack  in  1  one-cycle completion pulse, valid only while bus_req=1

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY, ABORT. Per-side flags: if_done, mem_done, each with a 32-bit hold register.
- Pending requests:
  - if_pend = if_ce & ~if_done.
  - mem_pend = mem_ce & ~mem_done.
- IDLE: if mem_pend, register the bus fields from the MEM inputs and go to MEM_BUSY. Otherwise, if if_pend, register them from if_addr (we=0, sel=4'b1111, wdata=0) and go to IF_BUSY. MEM has fixed priority. No grant is made while flush=1.
- BUSY states: bus_req and all bus fields are held stable until bus_ack.
- On ack in IF_BUSY or MEM_BUSY with flush=0:
  - Return to IDLE and deassert bus_req at the next edge.
  - If the consuming stall bit (stall[1] for IF, stall[4] for MEM) is 1 in the ack cycle, set the done flag and capture bus_rdata into the hold register.
- A done flag clears on the first edge where its stall bit is 0, or where flush=1.
- Flush in BUSY without ack: go to ABORT and keep bus_req asserted. The ack is awaited and its data discarded, then return to IDLE. Flush in an ack cycle discards the data and returns to IDLE.
- Output mux:
  - if_inst = bus_rdata in an IF_BUSY ack cycle with flush=0; else the hold register if if_done; else 0.
  - mem_rdata follows the same rule for the MEM side.
- Stall requests:
  - stallreq_if = if_pend & ~(IF_BUSY & bus_ack & ~flush).
  - stallreq_mem = mem_pend & ~(MEM_BUSY & bus_ack & ~flush).
- Write accesses follow the same flow; mem_rdata for a write is the don't-care bus_rdata and is still held.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_addr, bus_sel, bus_wdata, both flags and both hold registers all 0. if_inst, mem_rdata, stallreq_if and stallreq_mem are 0 in the cycle after reset.
- Reset mid-transaction: bus_req drops at the next edge and the transaction is dropped. The slave shares rst.
- Minimum access:
  - Cycle N: request seen in IDLE.
  - Cycle N+1: bus_req high; ack allowed in this same cycle; data out and stallreq low combinationally.
  - Cycle N+2: IDLE.
  - Result: one stall cycle per access at zero wait states.
- bus_req is low for at least one cycle between transactions.
- ABORT always finishes with exactly one ack. No new grant is made until that ack.

## Test plan
- Zero-wait fetch: if_ce=1, if_addr=0x0, stall=0, slave acks the first req cycle with 0x34010001. Required:
  - Cycle 1: bus_addr=0x0, if_inst=0x34010001, stallreq_if=0.
  - Cycle 2: bus_req=0.
- Conflict: in IDLE, IF pends 0x4 and MEM pends a write of 0xDEADBEEF to 0x100 with sel=4'hF. Required:
  - MEM is granted first with bus_we=1.
  - stallreq_if stays 1 until the IF ack on address 0x4, which occurs after the MEM ack plus one IDLE cycle.
- Hold across stall: IF ack returns 0x8C020000 while stall[1]=1 for 3 cycles. Required:
  - if_inst=0x8C020000 throughout those cycles, with no new bus_req.
  - After stall[1]=0, a new fetch follows.
- Wait states: slave acks 5 cycles after req. Required:
  - stallreq_mem=1 for 5 cycles, with bus_addr, bus_sel and bus_wdata unchanged.
  - mem_rdata equals bus_rdata in the ack cycle.
- Flush during IF_BUSY with a 3-cycle ack. Required:
  - bus_req stays 1 until the ack; if_inst=0 in the ack cycle.
  - The next grant uses the new if_addr.
- rst=1 during MEM_BUSY. Required: in the next cycle bus_req=0, stallreq_mem=0, mem_rdata=0, state IDLE.
